// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - execute stage: ALU, shifter, HI/LO moves, multiply, iterative divider
// Divider FSM and datapath are built only when STAGE_EX_DIVIDER_EN is defined.
module stage_ex #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ex_operator,
    input  logic [2:0]  ex_category,
    input  logic [31:0] ex_operand_a,
    input  logic [31:0] ex_operand_b,
    input  logic        ex_register_write_enable,
    input  logic [4:0]  ex_register_write_address,
    input  logic [31:0] ex_register_write_data,
    input  logic [31:0] hilo_hi,
    input  logic [31:0] hilo_lo,
    input  logic        stall_hold,
    output logic        mem_register_write_enable,
    output logic [4:0]  mem_register_write_address,
    output logic [31:0] mem_register_write_data,
    output logic        mem_hilo_write_enable,
    output logic [31:0] mem_hilo_write_hi,
    output logic [31:0] mem_hilo_write_lo,
    output logic        stall_request
);
    localparam logic [2:0] CAT_LOGIC = 3'd1;
    localparam logic [2:0] CAT_SHIFT = 3'd2;
    localparam logic [2:0] CAT_MOVE  = 3'd3;
    localparam logic [2:0] CAT_ARITH = 3'd4;
    localparam logic [2:0] CAT_JUMP  = 3'd6;

    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_SLTU  = 8'h2B;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] move_res;
    logic [31:0] arith_res;
    logic [4:0]  shamt;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    assign shamt  = ex_operand_a[4:0];
    assign prod_s = $signed(ex_operand_a) * $signed(ex_operand_b);
    assign prod_u = {32'd0, ex_operand_a} * {32'd0, ex_operand_b};

    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        move_res  = 32'd0;
        arith_res = 32'd0;
        case (ex_operator)
            OP_AND:  logic_res = ex_operand_a & ex_operand_b;
            OP_OR:   logic_res = ex_operand_a | ex_operand_b;
            OP_XOR:  logic_res = ex_operand_a ^ ex_operand_b;
            OP_NOR:  logic_res = ~(ex_operand_a | ex_operand_b);
            OP_SLL:  shift_res = ex_operand_b << shamt;
            OP_SRL:  shift_res = ex_operand_b >> shamt;
            OP_SRA:  shift_res = $unsigned($signed(ex_operand_b) >>> shamt);
            OP_MFHI: move_res  = hilo_hi;
            OP_MFLO: move_res  = hilo_lo;
            OP_ADDU: arith_res = ex_operand_a + ex_operand_b;
            OP_SUBU: arith_res = ex_operand_a - ex_operand_b;
            OP_SLT:  arith_res = {31'd0, $signed(ex_operand_a) < $signed(ex_operand_b)};
            OP_SLTU: arith_res = {31'd0, ex_operand_a < ex_operand_b};
            default: ;
        endcase
    end

`ifdef STAGE_EX_DIVIDER_EN
    localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {DIV_IDLE, DIV_ZERO, DIV_RUN, DIV_DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_signed;
    logic [32:0] partial;
    logic [32:0] diff;

    assign is_signed = (ex_operator == OP_DIV);
    // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder
    assign partial   = {rem_q, quot_q[31]};
    assign diff      = partial - {1'b0, divisor_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            count_q    <= '0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_stall  = 1'b0;
        div_done   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (ex_operator == OP_DIV || ex_operator == OP_DIVU) begin
                    div_stall  = 1'b1;
                    neg_quot_d = is_signed & (ex_operand_a[31] ^ ex_operand_b[31]);
                    neg_rem_d  = is_signed & ex_operand_a[31];
                    quot_d     = (is_signed && ex_operand_a[31]) ? 32'd0 - ex_operand_a : ex_operand_a;
                    divisor_d  = (is_signed && ex_operand_b[31]) ? 32'd0 - ex_operand_b : ex_operand_b;
                    rem_d      = 32'd0;
                    count_d    = '0;
                    state_d    = (ex_operand_b == 32'd0) ? DIV_ZERO : DIV_RUN;
                end
            end
            DIV_ZERO: begin
                div_stall = 1'b1;
                quot_d    = 32'd0;
                rem_d     = 32'd0;
                state_d   = DIV_DONE;
            end
            DIV_RUN: begin
                div_stall = 1'b1;
                if (!diff[32]) begin
                    rem_d  = diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = partial[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(DIV_STEPS - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                div_done = 1'b1;
                if (!stall_hold) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign div_hi = neg_rem_q  ? 32'd0 - rem_q  : rem_q;
    assign div_lo = neg_quot_q ? 32'd0 - quot_q : quot_q;
`else
    logic unused_div_inputs;
    assign unused_div_inputs = &{1'b0, clock, stall_hold};
    assign div_stall = 1'b0;
    assign div_done  = 1'b0;
    assign div_hi    = 32'd0;
    assign div_lo    = 32'd0;
`endif

    always_comb begin
        mem_register_write_enable  = 1'b0;
        mem_register_write_address = 5'd0;
        mem_register_write_data    = 32'd0;
        mem_hilo_write_enable      = 1'b0;
        mem_hilo_write_hi          = 32'd0;
        mem_hilo_write_lo          = 32'd0;
        stall_request              = 1'b0;
        // Outputs are combinational, so reset must force them low directly
        if (!reset) begin
            mem_register_write_enable  = ex_register_write_enable;
            mem_register_write_address = ex_register_write_address;
            stall_request              = div_stall;
            case (ex_category)
                CAT_LOGIC: mem_register_write_data = logic_res;
                CAT_SHIFT: mem_register_write_data = shift_res;
                CAT_MOVE:  mem_register_write_data = move_res;
                CAT_ARITH: mem_register_write_data = arith_res;
                CAT_JUMP:  mem_register_write_data = ex_register_write_data;
                default:   mem_register_write_data = 32'd0;
            endcase
            if (div_done) begin
                mem_hilo_write_enable = 1'b1;
                mem_hilo_write_hi     = div_hi;
                mem_hilo_write_lo     = div_lo;
            end else begin
                case (ex_operator)
                    OP_MTHI: begin
                        mem_hilo_write_enable = 1'b1;
                        mem_hilo_write_hi     = ex_operand_a;
                        mem_hilo_write_lo     = hilo_lo;
                    end
                    OP_MTLO: begin
                        mem_hilo_write_enable = 1'b1;
                        mem_hilo_write_hi     = hilo_hi;
                        mem_hilo_write_lo     = ex_operand_a;
                    end
                    OP_MULT: begin
                        mem_hilo_write_enable = 1'b1;
                        mem_hilo_write_hi     = prod_s[63:32];
                        mem_hilo_write_lo     = prod_s[31:0];
                    end
                    OP_MULTU: begin
                        mem_hilo_write_enable = 1'b1;
                        mem_hilo_write_hi     = prod_u[63:32];
                        mem_hilo_write_lo     = prod_u[31:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - directed vector bench for the execute stage
// Divider sequences are exercised when STAGE_EX_DIVIDER_EN is defined, NOP behaviour otherwise.
module tb_stage_ex;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ex_operator;
    logic [2:0]  ex_category;
    logic [31:0] ex_operand_a;
    logic [31:0] ex_operand_b;
    logic        ex_register_write_enable;
    logic [4:0]  ex_register_write_address;
    logic [31:0] ex_register_write_data;
    logic [31:0] hilo_hi;
    logic [31:0] hilo_lo;
    logic        stall_hold;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic        mem_hilo_write_enable;
    logic [31:0] mem_hilo_write_hi;
    logic [31:0] mem_hilo_write_lo;
    logic        stall_request;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    stage_ex dut (
        .clock                      (clock),
        .reset                      (reset),
        .ex_operator                (ex_operator),
        .ex_category                (ex_category),
        .ex_operand_a               (ex_operand_a),
        .ex_operand_b               (ex_operand_b),
        .ex_register_write_enable   (ex_register_write_enable),
        .ex_register_write_address  (ex_register_write_address),
        .ex_register_write_data     (ex_register_write_data),
        .hilo_hi                    (hilo_hi),
        .hilo_lo                    (hilo_lo),
        .stall_hold                 (stall_hold),
        .mem_register_write_enable  (mem_register_write_enable),
        .mem_register_write_address (mem_register_write_address),
        .mem_register_write_data    (mem_register_write_data),
        .mem_hilo_write_enable      (mem_hilo_write_enable),
        .mem_hilo_write_hi          (mem_hilo_write_hi),
        .mem_hilo_write_lo          (mem_hilo_write_lo),
        .stall_request              (stall_request)
    );

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  cat;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] hi_in;
        logic [31:0] lo_in;
        logic [31:0] exp_data;
        logic        exp_hwe;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] op, input logic [2:0] cat, input logic [31:0] a, input logic [31:0] b);
        ex_operator  = op;
        ex_category  = cat;
        ex_operand_a = a;
        ex_operand_b = b;
    endtask

    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input int exp_stalls, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls = 0;
        int dones  = 0;
        bit fin    = 0;
        set_in(op, 3'd5, a, b);
        stall_hold = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            @(negedge clock);
            if (mem_hilo_write_enable) begin
                if (dones == 0) begin
                    check({nm, "_stalls"}, stalls, exp_stalls);
                    check({nm, "_hi"}, mem_hilo_write_hi, exp_hi);
                    check({nm, "_lo"}, mem_hilo_write_lo, exp_lo);
                    check({nm, "_done_stall"}, stall_request, 1'b0);
                end
                dones++;
                stall_hold = (dones <= hold);
                if (!stall_hold) fin = 1;
            end else if (stall_request) begin
                stalls++;
            end else begin
                check({nm, "_idle_gap"}, 1'b1, 1'b0);
            end
            @(posedge clock);
            #1;
        end
        check({nm, "_finished"}, fin, 1'b1);
        check({nm, "_done_cycles"}, dones, hold + 1);
    endtask

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{8'h24, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd5,  32'h0, 32'h0, 32'h0, 32'hF000F000, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{8'h25, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd6,  32'h0, 32'h0, 32'h0, 32'hFFF0FFF0, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{8'h26, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5'd7,  32'h0, 32'h0, 32'h0, 32'h0FF00FF0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{8'h27, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd8,  32'h0, 32'h0, 32'h0, 32'h000F000F, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{8'h03, 3'd2, 32'h00000004, 32'h80000000, 1'b1, 5'd9,  32'h0, 32'h0, 32'h0, 32'hF8000000, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{8'h7C, 3'd2, 32'h00000024, 32'h000000F1, 1'b1, 5'd10, 32'h0, 32'h0, 32'h0, 32'h00000F10, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{8'h02, 3'd2, 32'h00000004, 32'h80000000, 1'b1, 5'd11, 32'h0, 32'h0, 32'h0, 32'h08000000, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{8'h2A, 3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 32'h00000001, 1'b0, 32'h0, 32'h0};
        vecs[8]  = '{8'h2B, 3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd13, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{8'h21, 3'd4, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5'd14, 32'h0, 32'h0, 32'h0, 32'h00000001, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{8'h23, 3'd4, 32'h00000000, 32'h00000001, 1'b1, 5'd15, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{8'h10, 3'd3, 32'h0, 32'h0, 1'b1, 5'd16, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{8'h12, 3'd3, 32'h0, 32'h0, 1'b1, 5'd17, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{8'h11, 3'd3, 32'hCAFEBABE, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000001, 32'h00000002, 32'h0, 1'b1, 32'hCAFEBABE, 32'h00000002};
        vecs[14] = '{8'h13, 3'd3, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000001, 32'h00000002, 32'h0, 1'b1, 32'h00000001, 32'hDEADBEEF};
        vecs[15] = '{8'h18, 3'd5, 32'hFFFFFFFE, 32'h00000003, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[16] = '{8'h19, 3'd5, 32'hFFFFFFFE, 32'h00000003, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h00000002, 32'hFFFFFFFA};
        vecs[17] = '{8'h00, 3'd6, 32'h11111111, 32'h22222222, 1'b1, 5'd31, 32'h00400008, 32'h0, 32'h0, 32'h00400008, 1'b0, 32'h0, 32'h0};
        vecs[18] = '{8'h55, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
        vecs[19] = '{8'h24, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};

        reset = 1'b1;
        stall_hold = 1'b0;
        hilo_hi = 32'h0;
        hilo_lo = 32'h0;
        ex_register_write_enable  = 1'b1;
        ex_register_write_address = 5'd5;
        ex_register_write_data    = 32'h0;
        set_in(8'h24, 3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
        repeat (2) @(negedge clock);
        check("reset_we", mem_register_write_enable, 1'b0);
        check("reset_addr", mem_register_write_address, 5'd0);
        check("reset_data", mem_register_write_data, 32'h0);
        check("reset_hwe", mem_hilo_write_enable, 1'b0);
        check("reset_stall", stall_request, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            set_in(vecs[i].op, vecs[i].cat, vecs[i].a, vecs[i].b);
            ex_register_write_enable  = vecs[i].we;
            ex_register_write_address = vecs[i].addr;
            ex_register_write_data    = vecs[i].wd;
            hilo_hi = vecs[i].hi_in;
            hilo_lo = vecs[i].lo_in;
            @(negedge clock);
            check($sformatf("v%0d_data", i), mem_register_write_data, vecs[i].exp_data);
            check($sformatf("v%0d_we", i), mem_register_write_enable, vecs[i].we);
            check($sformatf("v%0d_addr", i), mem_register_write_address, vecs[i].addr);
            check($sformatf("v%0d_hwe", i), mem_hilo_write_enable, vecs[i].exp_hwe);
            check($sformatf("v%0d_stall", i), stall_request, 1'b0);
            if (vecs[i].exp_hwe) begin
                check($sformatf("v%0d_hi", i), mem_hilo_write_hi, vecs[i].exp_hi);
                check($sformatf("v%0d_lo", i), mem_hilo_write_lo, vecs[i].exp_lo);
            end
        end

        @(posedge clock);
        #1;
        ex_register_write_enable  = 1'b0;
        ex_register_write_address = 5'd0;
`ifdef STAGE_EX_DIVIDER_EN
        run_div("div_neg", 8'h1A, 32'hFFFFFFF9, 32'h00000002, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clock);
        check("b2b_restart_stall", stall_request, 1'b1);
        check("b2b_restart_hwe", mem_hilo_write_enable, 1'b0);
        repeat (11) @(posedge clock);
        @(negedge clock);
        check("run10_stall", stall_request, 1'b1);
        ex_register_write_enable  = 1'b1;
        ex_register_write_address = 5'd7;
        reset = 1'b1;
        #1;
        check("rst_run_stall", stall_request, 1'b0);
        check("rst_run_hwe", mem_hilo_write_enable, 1'b0);
        check("rst_run_we", mem_register_write_enable, 1'b0);
        check("rst_run_addr", mem_register_write_address, 5'd0);
        @(negedge clock);
        reset = 1'b0;
        ex_register_write_enable  = 1'b0;
        ex_register_write_address = 5'd0;
        run_div("divu_100_7", 8'h1B, 32'd100, 32'd7, 0, 33, 32'h00000002, 32'h0000000E);
        run_div("divu_zero", 8'h1B, 32'h00000005, 32'h0, 3, 2, 32'h0, 32'h0);
        set_in(8'h00, 3'd0, 32'h0, 32'h0);
        @(negedge clock);
        check("post_div_stall", stall_request, 1'b0);
        check("post_div_hwe", mem_hilo_write_enable, 1'b0);
`else
        set_in(8'h1A, 3'd5, 32'hFFFFFFF9, 32'h00000002);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("nodiv_stall%0d", c), stall_request, 1'b0);
            check($sformatf("nodiv_hwe%0d", c), mem_hilo_write_enable, 1'b0);
            check($sformatf("nodiv_data%0d", c), mem_register_write_data, 32'h0);
        end
        @(posedge clock);
        #1;
        set_in(8'h1B, 3'd5, 32'h00000005, 32'h0);
        @(negedge clock);
        check("nodivu_stall", stall_request, 1'b0);
        check("nodivu_hwe", mem_hilo_write_enable, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
